// File: rtl/axi4_types.sv
// Shared AXI4-lite types plus the instruction-fetch state and entry definitions.
// fetch_entry_t carries a FETCH_ADDR_W-bit pc, so the fetch unit's ADDR_W should match it.
package axi4_types;

    localparam logic [1:0] AXI4_RESP_L_OKAY   = 2'b00;
    localparam logic [1:0] AXI4_RESP_L_EXOKAY = 2'b01;
    localparam logic [1:0] AXI4_RESP_L_SLVERR = 2'b10;
    localparam logic [1:0] AXI4_RESP_L_DECERR = 2'b11;

    localparam logic AXI4_PROT_INSTR = 1'b1;

    localparam int FETCH_ADDR_W = 32;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        DATA,
        DRAIN,
        HALT
    } fetch_state_e;

    typedef struct packed {
        logic [31:0]             data;
        logic [FETCH_ADDR_W-1:0] pc;
        logic                    fault;
    } fetch_entry_t;

    localparam int FETCH_ENTRY_W = $bits(fetch_entry_t);

    function automatic logic [2:0] make_arprot(input logic nonsecure, input logic priv);
        return {AXI4_PROT_INSTR, nonsecure, priv};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetch entries with flush, occupancy count and a head
// driven straight from storage flops (zero when empty).
module fetch_fifo
    import axi4_types::*;
#(
    parameter int DEPTH = 2,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     push,
    input  logic [FETCH_ENTRY_W-1:0] push_data,
    input  logic                     pop,
    output logic                     head_valid,
    output logic [FETCH_ENTRY_W-1:0] head_data,
    output logic [CNT_W-1:0]         count
);

    logic [FETCH_ENTRY_W-1:0] mem_q [DEPTH];
    logic [FETCH_ENTRY_W-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]         count_q, count_d;
    logic                     do_push;
    logic                     do_pop;

    assign head_valid = (count_q != '0);
    assign head_data  = head_valid ? mem_q[rd_ptr_q] : '0;
    assign count      = count_q;
    assign do_pop     = pop && head_valid;
    assign do_push    = push && (count_q != CNT_W'(DEPTH));

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        // Flush wins over any push/pop on the same edge.
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/axi_fetch_unit.sv
// Instruction-fetch AXI4-lite read master: one outstanding word read at a time,
// results buffered in fetch_fifo, non-OKAY responses become fault entries and halt fetch.
module axi_fetch_unit
    import axi4_types::*;
#(
    parameter int               ADDR_W     = FETCH_ADDR_W,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0,
    parameter int               FIFO_DEPTH = 2
) (
    input  logic              ACLK,
    input  logic              ARESETn,
    output logic [ADDR_W-1:0] araddr,
    output logic [2:0]        arprot,
    output logic              arvalid,
    input  logic              arready,
    input  logic [31:0]       rdata,
    input  logic [1:0]        rresp,
    input  logic              rvalid,
    output logic              rready,
    input  logic              priv,
    input  logic              nonsecure,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [31:0]       instr_data,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              instr_fault
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] araddr_q, araddr_d;
    logic [2:0]        arprot_q, arprot_d;
    logic              arvalid_q, arvalid_d;
    logic              rready_q, rready_d;
    logic              kill_q, kill_d;

    logic              ar_hs;
    logic              r_hs;
    logic              pop;
    logic              credit;
    logic              push;
    fetch_entry_t      push_entry;
    fetch_entry_t      head_entry;
    logic [CNT_W-1:0]  fifo_count;

    assign ar_hs  = arvalid_q && arready;
    assign r_hs   = rready_q && rvalid;
    assign pop    = instr_valid && instr_ready;
    assign credit = (fifo_count - CNT_W'(pop)) < CNT_W'(FIFO_DEPTH);

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        araddr_d   = araddr_q;
        arprot_d   = arprot_q;
        arvalid_d  = arvalid_q;
        rready_d   = rready_q;
        kill_d     = kill_q;
        push       = 1'b0;
        push_entry = '0;

        if (redirect_valid) begin
            pc_d = redirect_pc;
        end

        unique case (state_q)
            IDLE: begin
                if (!redirect_valid && credit) begin
                    araddr_d  = pc_q;
                    arprot_d  = make_arprot(nonsecure, priv);
                    arvalid_d = 1'b1;
                    state_d   = ADDR;
                end
            end
            ADDR: begin
                // A redirect cannot withdraw the request; remember it and drain later.
                if (ar_hs) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    kill_d    = 1'b0;
                    state_d   = (kill_q || redirect_valid) ? DRAIN : DATA;
                end else if (redirect_valid) begin
                    kill_d = 1'b1;
                end
            end
            DATA: begin
                if (r_hs) begin
                    rready_d = 1'b0;
                    if (redirect_valid) begin
                        state_d = IDLE;
                    end else if (rresp == AXI4_RESP_L_OKAY) begin
                        push             = 1'b1;
                        push_entry.data  = rdata;
                        push_entry.pc    = FETCH_ADDR_W'(araddr_q);
                        push_entry.fault = 1'b0;
                        pc_d             = pc_q + ADDR_W'(1);
                        state_d          = IDLE;
                    end else begin
                        push             = 1'b1;
                        push_entry.pc    = FETCH_ADDR_W'(araddr_q);
                        push_entry.fault = 1'b1;
                        state_d          = HALT;
                    end
                end else if (redirect_valid) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (r_hs) begin
                    rready_d = 1'b0;
                    state_d  = IDLE;
                end
            end
            HALT: begin
                if (redirect_valid) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            state_q   <= IDLE;
            pc_q      <= RESET_PC;
            araddr_q  <= '0;
            arprot_q  <= '0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            kill_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            araddr_q  <= araddr_d;
            arprot_q  <= arprot_d;
            arvalid_q <= arvalid_d;
            rready_q  <= rready_d;
            kill_q    <= kill_d;
        end
    end

    fetch_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk       (ACLK),
        .rst_n     (ARESETn),
        .flush     (redirect_valid),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .head_valid(instr_valid),
        .head_data (head_entry),
        .count     (fifo_count)
    );

    assign araddr      = araddr_q;
    assign arprot      = arprot_q;
    assign arvalid     = arvalid_q;
    assign rready      = rready_q;
    assign instr_data  = head_entry.data;
    assign instr_pc    = ADDR_W'(head_entry.pc);
    assign instr_fault = head_entry.fault;

endmodule

// File: tb/tb_axi_fetch_unit.sv
// Scoreboard bench for axi_fetch_unit: a ROM slave model answers reads, expected
// AR requests and fetched entries are queued per scenario and compared as they appear.
module tb_axi_fetch_unit;
    import axi4_types::*;

    localparam int ADDR_W = 32;

    logic              ACLK = 1'b0;
    logic              ARESETn;
    logic [ADDR_W-1:0] araddr;
    logic [2:0]        arprot;
    logic              arvalid;
    logic              arready = 1'b0;
    logic [31:0]       rdata;
    logic [1:0]        rresp;
    logic              rvalid = 1'b0;
    logic              rready;
    logic              priv;
    logic              nonsecure;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
    logic              instr_valid;
    logic              instr_ready;
    logic [31:0]       instr_data;
    logic [ADDR_W-1:0] instr_pc;
    logic              instr_fault;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [2:0]        prot;
    } exp_ar_t;

    typedef struct {
        logic [31:0]       data;
        logic [ADDR_W-1:0] pc;
        logic              fault;
    } exp_instr_t;

    exp_ar_t    exp_ar_q[$];
    exp_instr_t exp_instr_q[$];
    exp_ar_t    ea;
    exp_instr_t ei;

    int   checks   = 0;
    int   failures = 0;
    int   ar_seen  = 0;
    logic arready_en = 1'b1;
    int   r_delay    = 0;
    logic r_pending  = 1'b0;
    logic ar_hs_next = 1'b0;
    logic r_hs_next  = 1'b0;
    int   r_cnt      = 0;

    always #5 ACLK = ~ACLK;

    axi_fetch_unit dut (
        .ACLK          (ACLK),
        .ARESETn       (ARESETn),
        .araddr        (araddr),
        .arprot        (arprot),
        .arvalid       (arvalid),
        .arready       (arready),
        .rdata         (rdata),
        .rresp         (rresp),
        .rvalid        (rvalid),
        .rready        (rready),
        .priv          (priv),
        .nonsecure     (nonsecure),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .instr_data    (instr_data),
        .instr_pc      (instr_pc),
        .instr_fault   (instr_fault)
    );

    function automatic logic [31:0] rom_word(input logic [ADDR_W-1:0] a);
        return (a * 32'h9E37_79B9) ^ 32'hC0DE_0000;
    endfunction

    // Words 256..511 are privileged-only; the slave judges from the live address/prot.
    function automatic logic [1:0] slv_resp(input logic [ADDR_W-1:0] a, input logic [2:0] p);
        if (a >= 256 && a < 512 && !p[0]) return AXI4_RESP_L_SLVERR;
        return AXI4_RESP_L_OKAY;
    endfunction

    assign rdata = rom_word(araddr);
    assign rresp = slv_resp(araddr, arprot);

    // Slave and scoreboard: signal values seen at a negedge are those sampled at the next posedge.
    always @(negedge ACLK) begin
        if (!ARESETn) begin
            rvalid     = 1'b0;
            r_pending  = 1'b0;
            ar_hs_next = 1'b0;
            r_hs_next  = 1'b0;
            arready    = arready_en;
        end else begin
            if (r_hs_next) begin
                rvalid    = 1'b0;
                r_hs_next = 1'b0;
            end
            if (ar_hs_next) begin
                r_pending  = 1'b1;
                r_cnt      = r_delay;
                ar_hs_next = 1'b0;
            end
            if (r_pending && !rvalid) begin
                if (r_cnt == 0) begin
                    rvalid    = 1'b1;
                    r_pending = 1'b0;
                end else begin
                    r_cnt--;
                end
            end
            arready    = arready_en;
            ar_hs_next = arvalid && arready;
            r_hs_next  = rvalid && rready;
            if (ar_hs_next) begin
                ar_seen++;
                if (exp_ar_q.size() > 0) begin
                    ea = exp_ar_q.pop_front();
                    checks++;
                    if (araddr !== ea.addr || arprot !== ea.prot) begin
                        failures++;
                        $display("[TB] FAIL ar_request: got addr=%0d prot=%b, expected addr=%0d prot=%b",
                                 araddr, arprot, ea.addr, ea.prot);
                    end
                end
            end
            if (instr_valid && instr_ready && exp_instr_q.size() > 0) begin
                ei = exp_instr_q.pop_front();
                checks++;
                if (instr_data !== ei.data || instr_pc !== ei.pc || instr_fault !== ei.fault) begin
                    failures++;
                    $display("[TB] FAIL instr_entry: got data=%h pc=%0d fault=%b, expected data=%h pc=%0d fault=%b",
                             instr_data, instr_pc, instr_fault, ei.data, ei.pc, ei.fault);
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge ACLK);
        #1;
    endtask

    task automatic hold_reset(input int n);
        ARESETn = 1'b0;
        step(n);
    endtask

    task automatic clear_expect();
        exp_ar_q.delete();
        exp_instr_q.delete();
    endtask

    task automatic push_ar(input logic [ADDR_W-1:0] a, input logic [2:0] p);
        exp_ar_q.push_back('{addr: a, prot: p});
    endtask

    task automatic push_instr(input logic [31:0] d, input logic [ADDR_W-1:0] a, input logic f);
        exp_instr_q.push_back('{data: d, pc: a, fault: f});
    endtask

    task automatic wait_drained(input int bound, input string name);
        int k;
        k = 0;
        while ((exp_instr_q.size() != 0 || exp_ar_q.size() != 0) && k < bound) begin
            step(1);
            k++;
        end
        checks++;
        if (exp_instr_q.size() != 0 || exp_ar_q.size() != 0) begin
            failures++;
            $display("[TB] FAIL %s_drain: got %0d instr / %0d ar still pending after %0d cycles, expected 0/0",
                     name, exp_instr_q.size(), exp_ar_q.size(), bound);
        end
    endtask

    task automatic redirect_to(input logic [ADDR_W-1:0] a);
        redirect_valid = 1'b1;
        redirect_pc    = a;
        step(1);
        redirect_valid = 1'b0;
    endtask

    task automatic test_reset();
        priv = 0; nonsecure = 0; instr_ready = 1; redirect_valid = 0; redirect_pc = '0;
        arready_en = 1; r_delay = 1;
        hold_reset(3);
        checks++; if (arvalid !== 1'b0) begin failures++; $display("[TB] FAIL reset_arvalid: got %b expected 0", arvalid); end
        checks++; if (rready !== 1'b0) begin failures++; $display("[TB] FAIL reset_rready: got %b expected 0", rready); end
        checks++; if (araddr !== '0) begin failures++; $display("[TB] FAIL reset_araddr: got %0d expected 0", araddr); end
        checks++; if (arprot !== 3'b000) begin failures++; $display("[TB] FAIL reset_arprot: got %b expected 000", arprot); end
        checks++; if (instr_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_instr_valid: got %b expected 0", instr_valid); end
        checks++; if (instr_data !== '0 || instr_pc !== '0 || instr_fault !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_instr_fields: got data=%h pc=%0d fault=%b expected all 0", instr_data, instr_pc, instr_fault);
        end
    endtask

    task automatic test_rom_fetch();
        clear_expect();
        for (int i = 0; i < 3; i++) begin
            push_ar(ADDR_W'(i), 3'b100);
            push_instr(rom_word(ADDR_W'(i)), ADDR_W'(i), 1'b0);
        end
        ARESETn = 1'b1;
        wait_drained(200, "rom_fetch");
    endtask

    task automatic test_fault_halt();
        int busy;
        hold_reset(2);
        clear_expect();
        push_ar(256, 3'b100);
        push_instr(32'h0, 256, 1'b1);
        ARESETn = 1'b1;
        redirect_to(256);
        wait_drained(100, "fault");
        busy = 0;
        repeat (20) begin
            step(1);
            if (arvalid) busy++;
        end
        checks++;
        if (busy != 0) begin
            failures++;
            $display("[TB] FAIL halt_no_request: got arvalid high %0d cycles, expected 0", busy);
        end
        checks++;
        if (instr_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL halt_fifo_empty: got instr_valid=%b expected 0", instr_valid);
        end
    endtask

    task automatic test_halt_redirect_priv();
        priv = 1;
        clear_expect();
        push_ar(256, 3'b101);
        push_ar(257, 3'b101);
        push_instr(rom_word(256), 256, 1'b0);
        push_instr(rom_word(257), 257, 1'b0);
        redirect_to(256);
        wait_drained(100, "priv_refetch");
        priv = 0;
    endtask

    task automatic test_backpressure();
        int busy;
        r_delay = 0;
        instr_ready = 0;
        hold_reset(2);
        clear_expect();
        ar_seen = 0;
        push_ar(0, 3'b100);
        push_ar(1, 3'b100);
        ARESETn = 1'b1;
        step(30);
        busy = 0;
        repeat (20) begin
            step(1);
            if (arvalid) busy++;
        end
        checks++; if (ar_seen != 2) begin failures++; $display("[TB] FAIL full_read_count: got %0d expected 2", ar_seen); end
        checks++; if (busy != 0) begin failures++; $display("[TB] FAIL full_no_request: got arvalid high %0d cycles expected 0", busy); end
        checks++; if (instr_valid !== 1'b1 || instr_pc !== 0) begin
            failures++;
            $display("[TB] FAIL full_head: got valid=%b pc=%0d expected valid=1 pc=0", instr_valid, instr_pc);
        end
        push_ar(2, 3'b100);
        push_instr(rom_word(0), 0, 1'b0);
        instr_ready = 1;
        step(1);
        instr_ready = 0;
        step(20);
        checks++; if (ar_seen != 3) begin failures++; $display("[TB] FAIL refill_read_count: got %0d expected 3", ar_seen); end
        checks++; if (exp_ar_q.size() != 0 || exp_instr_q.size() != 0) begin
            failures++;
            $display("[TB] FAIL refill_pending: got %0d ar / %0d instr pending expected 0/0", exp_ar_q.size(), exp_instr_q.size());
        end
        checks++; if (instr_pc !== 1) begin failures++; $display("[TB] FAIL refill_head_pc: got %0d expected 1", instr_pc); end
    endtask

    task automatic test_redirect_in_data();
        int k;
        r_delay = 6;
        instr_ready = 1;
        hold_reset(2);
        clear_expect();
        for (int i = 0; i < 6; i++) push_ar(ADDR_W'(i), 3'b100);
        push_ar(768, 3'b100);
        for (int i = 0; i < 5; i++) push_instr(rom_word(ADDR_W'(i)), ADDR_W'(i), 1'b0);
        push_instr(rom_word(768), 768, 1'b0);
        ARESETn = 1'b1;
        k = 0;
        while (!(rready === 1'b1 && araddr === 5) && k < 300) begin
            step(1);
            k++;
        end
        checks++;
        if (k >= 300) begin
            failures++;
            $display("[TB] FAIL reach_data_5: got timeout after %0d cycles expected DATA phase of address 5", k);
        end
        redirect_to(768);
        checks++;
        if (instr_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL flush_empty: got instr_valid=%b expected 0", instr_valid);
        end
        wait_drained(300, "redirect_data");
    endtask

    task automatic test_reset_in_addr();
        int k;
        r_delay = 0;
        instr_ready = 0;
        nonsecure = 1;
        hold_reset(2);
        clear_expect();
        push_ar(0, 3'b110);
        push_ar(1, 3'b110);
        push_instr(rom_word(0), 0, 1'b0);
        ARESETn = 1'b1;
        step(30);
        arready_en = 0;
        instr_ready = 1;
        step(1);
        instr_ready = 0;
        k = 0;
        while (arvalid !== 1'b1 && k < 20) begin
            step(1);
            k++;
        end
        checks++;
        if (arvalid !== 1'b1 || araddr !== 2) begin
            failures++;
            $display("[TB] FAIL stall_in_addr: got arvalid=%b addr=%0d expected arvalid=1 addr=2", arvalid, araddr);
        end
        hold_reset(1);
        checks++; if (arvalid !== 1'b0 || araddr !== '0 || arprot !== 3'b000 || rready !== 1'b0) begin
            failures++;
            $display("[TB] FAIL rst_ar_outputs: got arvalid=%b addr=%0d prot=%b rready=%b expected all 0", arvalid, araddr, arprot, rready);
        end
        checks++; if (instr_valid !== 1'b0 || instr_data !== '0 || instr_pc !== '0 || instr_fault !== 1'b0) begin
            failures++;
            $display("[TB] FAIL rst_instr_outputs: got valid=%b data=%h pc=%0d fault=%b expected all 0", instr_valid, instr_data, instr_pc, instr_fault);
        end
        checks++; if (exp_ar_q.size() != 0 || exp_instr_q.size() != 0) begin
            failures++;
            $display("[TB] FAIL pre_reset_pending: got %0d ar / %0d instr pending expected 0/0", exp_ar_q.size(), exp_instr_q.size());
        end
        push_ar(0, 3'b110);
        push_ar(1, 3'b110);
        push_instr(rom_word(0), 0, 1'b0);
        push_instr(rom_word(1), 1, 1'b0);
        arready_en  = 1;
        instr_ready = 1;
        ARESETn     = 1'b1;
        wait_drained(200, "restart");
        nonsecure = 0;
    endtask

    initial begin
        ARESETn = 1'b0;
        priv = 0; nonsecure = 0; instr_ready = 0; redirect_valid = 0; redirect_pc = '0;
        test_reset();
        test_rom_fetch();
        test_fault_halt();
        test_halt_redirect_priv();
        test_backpressure();
        test_redirect_in_data();
        test_reset_in_addr();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got simulation still running at 500000 expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/axi_fetch_unit.md
Name: axi_fetch_unit

Overview:
- Instruction-fetch master directly upstream of the AXI4-lite instruction ROM in the frontend.
- Holds the PC and issues one word-addressed AXI4-lite read at a time, with `arprot` built from the current privilege and security mode.
- Buffers returned words in a 2-entry FIFO toward decode.
- Converts a non-OKAY `rresp` into a tagged fault entry and stops fetching until redirected.

Parameters:
- ADDR_W, 32, width of `araddr`, PC and redirect address (word address; PC increments by 1).
- RESET_PC, 0, PC loaded on reset.
- FIFO_DEPTH, 2, output buffer entries (power of 2, ≥2).

Ports:
- ACLK  in  1  clock
- ARESETn  in  1  synchronous active-low reset
- araddr  out  ADDR_W  AXI read address (word index)
- arprot  out  3  {1'b1 instruction, nonsecure, priv}
- arvalid  out  1  read address valid
- arready  in  1  read address ready
- rdata  in  32  read data
- rresp  in  2  read response (axi4_types resp encoding)
- rvalid  in  1  read data valid
- rready  out  1  read data ready
- priv  in  1  1 = privileged mode
- nonsecure  in  1  1 = non-secure mode
- redirect_valid  in  1  flush and restart fetch at redirect_pc
- redirect_pc  in  ADDR_W  new fetch address
- instr_valid  out  1  FIFO head valid
- instr_ready  in  1  decode accepts head
- instr_data  out  32  fetched word (0 when faulted)
- instr_pc  out  ADDR_W  address of the word
- instr_fault  out  1  1 = rresp was not OKAY

Behaviour:
- Reset (ARESETn low at a rising edge):
  - pc=RESET_PC, state=IDLE, FIFO empty, arvalid=0, rready=0, araddr=0, arprot=0.
  - instr_valid=0, instr_data=0, instr_pc=0, instr_fault=0.
  - Reset mid-transaction abandons it; no response is accepted afterwards.
- State IDLE: if credit available (FIFO free entries ≥1 after this cycle's pop):
  - latch araddr=pc and arprot={1,nonsecure,priv};
  - assert arvalid next cycle, go ADDR.
- State ADDR:
  - arvalid=1; araddr and arprot stable until the AR handshake.
  - On arvalid&&arready: arvalid<=0, go DATA.
- State DATA:
  - rready=1 (FIFO space already reserved).
  - araddr and arprot stay stable until the R handshake, because the slave evaluates rresp from the live address and protection.
- R handshake in DATA, rresp==OKAY:
  - push {rdata, araddr, fault=0}; pc<=pc+1 (wraps modulo 2^ADDR_W); go IDLE.
- R handshake in DATA, rresp!=OKAY:
  - push {0, araddr, fault=1}; pc unchanged; go HALT.
- State DRAIN: rready=1; discard the response on handshake; go IDLE with the already-loaded redirect pc.
- State HALT: no requests until redirect_valid.
- redirect_valid, any state:
  - FIFO flushed same edge; pc<=redirect_pc.
  - IDLE/HALT → IDLE.
  - ADDR: keep arvalid and araddr until handshake (AXI forbids withdrawal), then go DRAIN.
  - DATA → DRAIN, or IDLE if the R handshake occurs this same cycle; that response is discarded.
- Redirect during DRAIN: pc updated, remain DRAIN.
- Simultaneous redirect and instr handshake: the pop counts as consumed; the flush still empties everything else.
- Simultaneous push and pop on a full FIFO: not reachable, because credit is reserved at issue.
- Latency:
  - AR issued one cycle after entering IDLE with credit.
  - Word visible on instr_valid the cycle after the R handshake (FIFO output registered).
- At most one outstanding read. priv/nonsecure changes take effect on the next issued request only.

Decomposition:
- Add to shared package axi4_types:
  - fetch_state_e {IDLE, ADDR, DATA, DRAIN, HALT};
  - AXI4_PROT_INSTR = 1'b1;
  - fetch_entry_t {data[31:0], pc[ADDR_W-1:0], fault}.
- Reuse the existing AXI4_RESP_L_* constants.
- Sub-module: fetch_fifo, a synchronous FIFO with flush, count output, and registered head. It carries fetch_entry_t.

Test Plan:
- Reset, then priv=0, nonsecure=0, instr_ready=1, ROM slave: arprot=3'b100 on araddr 0,1,2 in order; instr_pc 0,1,2 with instr_data=mem[0..2]; instr_fault=0.
- redirect_pc=256 with priv=0, nonsecure=0: slave returns SLVERR; one entry with instr_pc=256, instr_fault=1, instr_data=0; arvalid stays 0 for ≥20 cycles (HALT).
- From HALT, priv=1 and redirect to 256: arprot=3'b101; OKAY response; instr_data=mem[256], fault=0; fetch continues at 257.
- instr_ready=0 from reset: exactly 2 reads complete; arvalid stays 0 while the FIFO is full; one pop → one new read of address 2.
- redirect_valid to 768 while in DATA: in-flight word at 5 is never output; next instr_pc=768; FIFO empty the cycle after redirect.
- ARESETn low for 1 cycle while in ADDR: all outputs return to reset values; fetching restarts at RESET_PC with no stale entry.
